// File: rtl/array_pkg.sv
// Shared encodings for the MAC array edge feeders: lane instructions, command codes, feeder FSM states.
package array_pkg;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam logic CMD_LOAD = 1'b0;
    localparam logic CMD_EXEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [1:0] cmd_to_inst(input logic cmd);
        if (cmd == CMD_EXEC)
            return INST_EXEC;
        else if (cmd == CMD_LOAD)
            return INST_LOAD;
        else
            return INST_IDLE;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-length delay chain of W-bit registers with async active-low clear; LEN >= 1 cycles of latency.
// No backpressure: shifts every cycle.
module skew_line #(
    parameter int W   = 6,
    parameter int LEN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [LEN];
    logic [W-1:0] stage_d [LEN];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < LEN; i++)
            stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++)
                stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < LEN; i++)
                stage_q[i] <= stage_d[i];
        end
    end

    assign dout = stage_q[LEN-1];

endmodule

// File: rtl/l0_skew_feeder.sv
// West-edge feeder: FIFO-buffered row vectors launched one per cycle, lane r delayed r extra cycles.
// Pop to lane-0 output is 1 cycle; a push while full is dropped unless a pop frees the slot that cycle.
// Optional L0_FEEDER_OCC_EN adds registered occupancy and almost_full outputs.
module l0_skew_feeder
    import array_pkg::*;
#(
    parameter int row   = 8,
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [row*bw-1:0]     in,
    input  logic                  wr,
    output logic                  full,
    output logic                  empty,
    input  logic                  start,
    input  logic                  cmd,
    input  logic [7:0]            len,
    output logic                  busy,
    output logic                  done,
    output logic [row*bw-1:0]     out,
    output logic [row*2-1:0]      inst_out
`ifdef L0_FEEDER_OCC_EN
    ,
    output logic [$clog2(depth):0] occ,
    output logic                   almost_full
`endif
);

    localparam int AW = $clog2(depth);
    localparam int LW = bw + 2;
    localparam int DW = (row > 1) ? $clog2(row) : 1;

    // FIFO storage and pointers
    logic [row*bw-1:0] mem_q [depth];
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [row*bw-1:0] rd_dat;
    logic              push, pop;

    // Command FSM and counters
    state_t            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic              cmd_q, cmd_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              done_q, done_d;

    // Per-lane launch register and skewed outputs
    logic [LW-1:0]     lane0_q [row];
    logic [LW-1:0]     lane0_d [row];
    logic [LW-1:0]     lane_out [row];

    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign push   = wr && (!full || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pop && cnt_q == 9'd1) state_d = DRAIN;
            DRAIN:   if (drain_q == DW'(row - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        pop    = (state_q == RUN) && !empty && (cnt_q != 9'd0);
        done_d = (state_q == DRAIN) && (drain_q == DW'(row - 1));
        for (int r = 0; r < row; r++)
            lane0_d[r] = pop ? {cmd_to_inst(cmd_q), rd_dat[r*bw +: bw]} : {INST_IDLE, {bw{1'b0}}};
    end

    always_comb begin
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        drain_d  = (state_q == DRAIN) ? drain_q + DW'(1) : '0;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        if (state_q == IDLE && start) begin
            cnt_d = (len == 8'd0) ? 9'd256 : {1'b0, len};
            cmd_d = cmd;
        end else if (pop) begin
            cnt_d = cnt_q - 9'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            cmd_q    <= 1'b0;
            drain_q  <= '0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int r = 0; r < row; r++)
                lane0_q[r] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int r = 0; r < row; r++)
                lane0_q[r] <= lane0_d[r];
        end
    end

    // Storage is not reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= in;
    end

    assign done        = done_q;
    assign lane_out[0] = lane0_q[0];

    for (genvar r = 1; r < row; r++) begin : g_skew
        skew_line #(
            .W   (LW),
            .LEN (r)
        ) u_skew (
            .clk   (clk),
            .rst_n (reset),
            .din   (lane0_q[r]),
            .dout  (lane_out[r])
        );
    end

    for (genvar r = 0; r < row; r++) begin : g_out
        assign out[r*bw +: bw]    = lane_out[r][bw-1:0];
        assign inst_out[r*2 +: 2] = lane_out[r][LW-1:bw];
    end

`ifdef L0_FEEDER_OCC_EN
    logic [AW:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            occ_q <= '0;
        else
            occ_q <= occ_d;
    end

    assign occ         = occ_q;
    assign almost_full = (occ_q >= (AW+1)'(depth - row));
`endif

endmodule

// File: tb/tb_l0_skew_feeder.sv
// Randomized scoreboard bench for l0_skew_feeder: predicted lane tokens are queued at stimulus time
// and a negedge monitor checks every lane's data, instruction and skew timing.
module tb_l0_skew_feeder;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int VW    = ROW * BW;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [VW-1:0]     in_v  = '0;
    logic              wr    = 1'b0;
    logic              start = 1'b0;
    logic              cmd   = 1'b0;
    logic [7:0]        len   = '0;
    logic              full, empty, busy, done;
    logic [VW-1:0]     out_v;
    logic [ROW*2-1:0]  inst_v;
`ifdef L0_FEEDER_OCC_EN
    logic [6:0]        occ;
    logic              almost_full;
`endif

    l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .in       (in_v),
        .wr       (wr),
        .full     (full),
        .empty    (empty),
        .start    (start),
        .cmd      (cmd),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .out      (out_v),
        .inst_out (inst_v)
`ifdef L0_FEEDER_OCC_EN
        ,
        .occ         (occ),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]    inst;
        logic [VW-1:0] vec;
    } tok_t;

    logic [VW-1:0] mq[$];      // vectors in the feeder FIFO not yet bound to a command
    tok_t          exp_q[$];   // launch order, in FIFO order, with the instruction each will carry
    int            rd_idx[ROW];
    int            l0_cyc[$];  // cycle each token appeared on lane 0
    int            pend = 0;
    logic [1:0]    pinst = 2'b00;
    int            total = 0;
    int            bad = 0;
    int            t0 = 0;
    int            last_push = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int r = 0; r < ROW; r++) begin
            logic [1:0]    ist;
            logic [BW-1:0] d;
            tok_t          t;
            ist = inst_v[r*2 +: 2];
            d   = out_v[r*BW +: BW];
            if (ist == 2'b00) begin
                chk($sformatf("bubble_data_l%0d", r), 64'(d), 64'd0);
            end else if (rd_idx[r] >= exp_q.size()) begin
                chk($sformatf("unexpected_token_l%0d", r), 64'(ist), 64'd0);
            end else begin
                t = exp_q[rd_idx[r]];
                chk($sformatf("inst_l%0d", r), 64'(ist), 64'(t.inst));
                chk($sformatf("data_l%0d", r), 64'(d), 64'(t.vec[r*BW +: BW]));
                if (r == 0)
                    l0_cyc.push_back(cyc);
                else if (rd_idx[r] < l0_cyc.size())
                    chk($sformatf("skew_l%0d", r), 64'(cyc - l0_cyc[rd_idx[r]]), 64'(r));
                else
                    chk($sformatf("lane_ahead_of_l0_l%0d", r), 64'(rd_idx[r]), 64'(l0_cyc.size()));
                rd_idx[r]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict();
        while (pend > 0 && mq.size() > 0) begin
            tok_t t;
            t.inst = pinst;
            t.vec  = mq.pop_front();
            exp_q.push_back(t);
            pend--;
        end
    endtask

    task automatic push_vec(input logic [VW-1:0] v, input bit acc);
        wr   = 1'b1;
        in_v = v;
        tick();
        wr   = 1'b0;
        in_v = '0;
        last_push = cyc;
        if (acc) begin
            mq.push_back(v);
            predict();
        end
    endtask

    task automatic start_cmd(input logic c, input int n);
        start = 1'b1;
        cmd   = c;
        len   = 8'(n);
        tick();
        start = 1'b0;
        t0    = cyc;
        pend  = n;
        pinst = c ? 2'b10 : 2'b01;
        predict();
        chk("busy_rise", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int dcyc);
        int k;
        k = 0;
        while (!done && k < 2000) begin
            tick();
            k++;
        end
        if (!done) begin
            chk("done_timeout", 64'd0, 64'd1);
            dcyc = -1;
        end else begin
            chk("busy_fall_with_done", 64'(busy), 64'd0);
            dcyc = cyc;
            tick();
            chk("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int r = 0; r < ROW; r++)
            v[r*BW +: BW] = BW'(r + 1);
        return v;
    endfunction

    task automatic directed_load4(input string tag);
        int base, dc;
        for (int i = 0; i < 4; i++)
            push_vec(ramp_vec(), 1'b1);
        base = l0_cyc.size();
        start_cmd(1'b0, 4);
        wait_done(dc);
        chk({tag, "_done_latency"}, 64'(dc - t0), 64'd12);
        chk({tag, "_lane0_count"}, 64'(l0_cyc.size() - base), 64'd4);
        if (l0_cyc.size() > base)
            chk({tag, "_lane0_first"}, 64'(l0_cyc[base] - t0), 64'd1);
    endtask

    task automatic check_lanes_complete(input string tag);
        for (int r = 0; r < ROW; r++)
            chk($sformatf("%s_tokens_l%0d", tag, r), 64'(rd_idx[r]), 64'(exp_q.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, want finish", cyc);
        $fatal(1);
    end

    initial begin
        int dc, base, n, need, extra, L;
        logic c;

        foreach (rd_idx[i]) rd_idx[i] = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        tick();

        chk("reset_out", 64'(out_v), 64'd0);
        chk("reset_inst", 64'(inst_v), 64'd0);
        chk("reset_empty", 64'(empty), 64'd1);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
`ifdef L0_FEEDER_OCC_EN
        chk("reset_occ", 64'(occ), 64'd0);
`endif

        directed_load4("load4");

        // Execute with a 5-cycle empty gap before the third vector
        push_vec(VW'($urandom), 1'b1);
        push_vec(VW'($urandom), 1'b1);
        base = l0_cyc.size();
        start_cmd(1'b1, 3);
        repeat (6) tick();
        push_vec(VW'($urandom), 1'b1);
        wait_done(dc);
        chk("gap_done_latency", 64'(dc - t0), 64'd16);
        if (l0_cyc.size() >= base + 3) begin
            chk("gap_back_to_back", 64'(l0_cyc[base+1] - l0_cyc[base]), 64'd1);
            chk("gap_stall_span", 64'(l0_cyc[base+2] - l0_cyc[base+1]), 64'd6);
        end else begin
            chk("gap_lane0_count", 64'(l0_cyc.size() - base), 64'd3);
        end

        // Fill to depth, drop one push, then push-while-full during the run
        chk("prefill_empty", 64'(empty), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            push_vec(VW'($urandom), 1'b1);
`ifdef L0_FEEDER_OCC_EN
            chk("fill_occ", 64'(occ), 64'(i + 1));
            chk("fill_almost_full", 64'(almost_full), 64'((i + 1) >= DEPTH - ROW));
`endif
        end
        chk("full_at_depth", 64'(full), 64'd1);
        chk("not_empty_at_depth", 64'(empty), 64'd0);
        push_vec(VW'($urandom), 1'b0);
        chk("full_after_drop", 64'(full), 64'd1);
`ifdef L0_FEEDER_OCC_EN
        chk("occ_after_drop", 64'(occ), 64'(DEPTH));
`endif
        start_cmd(1'b1, DEPTH + 6);
        push_vec(VW'($urandom), 1'b1);
        chk("full_after_push_pop", 64'(full), 64'd1);
        for (int i = 0; i < 5; i++)
            push_vec(VW'($urandom), 1'b1);
        wait_done(dc);
        chk("full_run_latency", 64'(dc - t0), 64'(DEPTH + 6 + ROW));
        chk("full_run_drained", 64'(empty), 64'd1);

`ifdef L0_FEEDER_OCC_EN
        for (int i = 0; i < DEPTH - ROW; i++)
            push_vec(VW'($urandom), 1'b1);
        chk("af_rise_56", 64'(almost_full), 64'd1);
        start_cmd(1'b0, 1);
        wait_done(dc);
        chk("af_occ_55", 64'(occ), 64'(DEPTH - ROW - 1));
        chk("af_fall_55", 64'(almost_full), 64'd0);
        start_cmd(1'b1, DEPTH - ROW - 1);
        wait_done(dc);
        chk("af_drained_occ", 64'(occ), 64'd0);
`endif

        // len=0 streams 256 vectors; pointers wrap several times
        start_cmd(1'b1, 256);
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            push_vec(VW'($urandom), 1'b1);
        end
        wait_done(dc);
        chk("stream_done_after_last_push", 64'(dc - last_push), 64'(1 + ROW));

        // Random commands with random pre-fill and trickled pushes
        for (int it = 0; it < 10; it++) begin
            n = (mq.size() < 16) ? int'($urandom_range(0, 6)) : 0;
            for (int j = 0; j < n; j++)
                push_vec(VW'($urandom), 1'b1);
            L = int'($urandom_range(1, 12));
            c = 1'($urandom_range(0, 1));
            start_cmd(c, L);
            need  = pend;
            extra = int'($urandom_range(0, 2));
            for (int j = 0; j < need + extra; j++) begin
                repeat ($urandom_range(0, 3)) tick();
                push_vec(VW'($urandom), 1'b1);
            end
            wait_done(dc);
            chk("rand_min_latency", 64'((dc - t0) >= (L + ROW)), 64'd1);
        end
        repeat (2) tick();
        check_lanes_complete("pre_reset");

        // Asynchronous reset in the middle of a run
        for (int i = 0; i < 6; i++)
            push_vec(VW'($urandom), 1'b1);
        start_cmd(1'b0, 6);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_rst_out", 64'(out_v), 64'd0);
        chk("midrun_rst_inst", 64'(inst_v), 64'd0);
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_done", 64'(done), 64'd0);
        chk("midrun_rst_empty", 64'(empty), 64'd1);
        chk("midrun_rst_full", 64'(full), 64'd0);
        mq.delete();
        exp_q.delete();
        l0_cyc.delete();
        foreach (rd_idx[i]) rd_idx[i] = 0;
        pend = 0;
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 64'(empty), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        directed_load4("cold");
        repeat (2) tick();
        check_lanes_complete("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l0_skew_feeder.md
# l0_skew_feeder

West-edge input feeder for the 2D MAC array. Buffers row vectors (weights for kernel loading, activations for execution) in an internal FIFO. Launches one vector per cycle under a command FSM. Skews row r by r cycles and drives each row's data and 2-bit instruction into column 0 of the array (`in_w` / `inst_w`).

## Interface
- `row`, 8: number of array rows / lanes per vector
- `bw`, 4: data bits per lane
- `depth`, 64: FIFO entries (power of two)
- `clk` input 1: single clock, rising edge
- `reset` input 1: asynchronous, active-low reset
- `in` input row*bw: write vector; lane r at bits [r*bw +: bw]
- `wr` input 1: push request
- `full` output 1: FIFO full; a push while full and not popping is dropped
- `empty` output 1: FIFO empty
- `start` input 1: one-cycle command strobe, honoured only in IDLE
- `cmd` input 1: 0 = kernel load, 1 = execute; sampled with `start`
- `len` input 8: vectors to launch; 0 means 256
- `busy` output 1: FSM not in IDLE
- `done` output 1: one-cycle pulse when the last skewed lane has been driven
- `out` output row*bw: per-row data to the array's west edge
- `inst_out` output row*2: per-row instruction; bit1 = execute, bit0 = kernel load

## Operation
- FSM states:
  - IDLE → RUN on `start`; `cmd` and `len` are latched into registers.
  - RUN pops one vector per cycle while `!empty` and the remaining count is > 0.
  - RUN → DRAIN when the count reaches 0.
  - DRAIN lasts row cycles, then → IDLE with `done`.
- Pop cycle in RUN: lane-0 instruction = 2'b01 (load) or 2'b10 (execute).
- Stall cycle in RUN (FIFO empty): lane-0 instruction = 2'b00, data = 0, count unchanged. Bubbles propagate through the skew like data.
- IDLE and DRAIN issue 2'b00 at lane 0.
- Skew: lane r's data and instruction pass through r additional register stages beyond the lane-0 output register.
- `start` outside IDLE is ignored; no queuing.
- Push and pop in the same cycle:
  - Always legal when not empty.
  - When full, the push is accepted because the pop frees an entry.
- Read/write pointers are log2(depth)+1 bits.
  - full = MSBs differ and low bits equal.
  - empty = pointers equal.
  - Pointers wrap naturally.
- Reset (asserted at any time, including mid-RUN/DRAIN):
  - Pointers, skew registers and FSM cleared immediately.
  - `out` = 0, `inst_out` = 0, `busy` = 0, `done` = 0, `full` = 0, `empty` = 1.
  - In-flight vectors are discarded.

## Timing
- Push at edge t: data is visible to a pop at edge t+1 (no fall-through); `empty` deasserts after edge t.
- Pop at edge t: lane 0 drives `out`/`inst_out` after edge t; lane r drives after edge t+r.
- `done` is high for exactly one cycle: the cycle after lane row-1 carries the final launched vector.
- Minimum `start`-to-`done` time, with the FIFO pre-filled: len + row cycles.
- `busy` rises the cycle after `start` and falls with `done`.

## Configuration
- `L0_FEEDER_OCC_EN` defined:
  - Adds output `occ`, width log2(depth)+1 (registered FIFO occupancy).
  - Adds output `almost_full`, asserted when occ ≥ depth−row.
- `L0_FEEDER_OCC_EN` undefined: neither port exists; all other behaviour is identical.

## Structure
- Shared package `array_pkg`:
  - instruction encodings `INST_IDLE`=2'b00, `INST_LOAD`=2'b01, `INST_EXEC`=2'b10
  - FSM state typedef (IDLE, RUN, DRAIN)
  - command encodings `CMD_LOAD`=0, `CMD_EXEC`=1
- One sub-module, `skew_line`: parameterised delay chain of (bw+2)-bit registers with async active-low clear, instantiated once per lane with length r.

## Test plan
- Reset then idle:
  - `out`=0, `inst_out`=0, `empty`=1, `full`=0, `busy`=0.
- Push 4 vectors (each lane r = r+1); `start`, `cmd`=0, `len`=4:
  - lane 0 shows 01 with data 1 for 4 cycles starting the cycle after the first pop;
  - lane 7 shows 01 with data 8, 7 cycles later;
  - `done` at len+row = 12 cycles after `start`.
- Execute with an empty gap:
  - `len`=3 with only 2 vectors queued; 3rd pushed 5 cycles later.
  - Lane 0 shows 10,10, five cycles of 00, then 10; `done` is delayed by 5 cycles.
- Fill to 64:
  - `full`=1 and a further push is dropped (occupancy stays 64).
  - Simultaneous push and pop while full is accepted; `full` remains 1.
  - Pointer wrap after 3×depth traffic preserves FIFO order.
- Assert `reset` low mid-RUN:
  - all outputs return to 0 asynchronously (before the next edge); FIFO empty.
  - After release, a new `start` behaves as from cold.
- With `L0_FEEDER_OCC_EN`:
  - `occ` tracks pushes/pops exactly;
  - `almost_full` rises at occ=56 and falls at 55.
